tb_rdout_mux_ctrl: RTL

Multi-channel, parametrised readout controller for the radiation-test readout path. It accepts snapshot requests from C independent K-word channels and serves them round-robin. For each request it captures the channel's K×N-bit data bus and writes one framed packet into a downstream FIFO: header, K data words, checksum, footer. It replaces the single-channel, fixed-header controller and adds channel tagging, frame numbering, a checksum, and overrun detection.

---
 rtl/tb_rdout_mux_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tb_rdout_mux_ctrl.sv
// Round-robin multi-channel readout controller: snapshots one channel's K words
// and writes a framed packet (header, data, XOR checksum, footer) to a FIFO.
//
// state  | meaning
// IDLE   | no frame in progress, waiting for a pending request
// LOAD   | capture selected channel into snapshot, clear counter/checksum
// HEADER | present header word, advance on write
// DATA   | present snapshot word wcnt, advance on write
// CHECK  | present XOR checksum, advance on write
// FOOTER | present footer word, frame counted on write
module tb_rdout_mux_ctrl #(
  parameter int unsigned N = 32,
  parameter int unsigned K = 576,
  parameter int unsigned C = 4
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic [C-1:0]     trig_i,
  input  logic [C*K*N-1:0] data_i,
  input  logic             fifo_full_i,
  input  logic             fifo_almst_full_i,
  output logic             fifo_wr_o,
  output logic [N-1:0]     fifo_data_o,
  output logic             busy_o,
  output logic [15:0]      frame_cnt_o,
  output logic [C-1:0]     pending_o,
  output logic [C-1:0]     overrun_o
);

  localparam int unsigned CW = (C > 1) ? $clog2(C) : 1;
  localparam int unsigned WW = (K > 1) ? $clog2(K) : 1;
  localparam logic [WW-1:0] LAST_W = WW'(K - 1);
  localparam logic [N-1:0]  FOOTER_W = N'({8'hFF, 8'h00, 16'(K)});

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_HEADER = 3'd2,
    S_DATA   = 3'd3,
    S_CHECK  = 3'd4,
    S_FOOTER = 3'd5
  } state_t;

  state_t          state_q, state_d;
  logic [C-1:0]    pending_q, pending_d;
  logic [C-1:0]    overrun_q, overrun_d;
  logic [C-1:0]    clr_mask;
  logic [CW-1:0]   last_q;
  logic [CW-1:0]   ch_q;
  logic [CW-1:0]   arb_ch;
  logic [CW-1:0]   idx;
  logic [WW-1:0]   wcnt_q;
  logic [N-1:0]    csum_q;
  logic [15:0]     frame_cnt_q;
  logic [K*N-1:0]  snap_q;
  logic [N-1:0]    data_word;
  logic [N-1:0]    header_w;
  logic            wr_ok;

  // Walk candidates from farthest to nearest so the nearest pending channel wins.
  always_comb begin
    arb_ch = last_q;
    idx    = '0;
    for (int i = int'(C); i >= 1; i--) begin
      idx = CW'((int'(last_q) + i) % int'(C));
      if (pending_q[idx]) arb_ch = idx;
    end
  end

  assign clr_mask  = (state_q == S_LOAD) ? (C'(1) << ch_q) : '0;
  assign pending_d = trig_i | (pending_q & ~clr_mask);
  assign overrun_d = overrun_q | (trig_i & pending_q & ~clr_mask);

  assign data_word = snap_q[int'(wcnt_q)*N +: N];
  assign header_w  = N'({8'hAA, 8'(ch_q), frame_cnt_q});
  assign wr_ok     = (state_q inside {S_HEADER, S_DATA, S_CHECK, S_FOOTER}) &&
                     !fifo_almst_full_i && !fifo_full_i;

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (|pending_q) state_d = S_LOAD;
      S_LOAD:   state_d = S_HEADER;
      S_HEADER: if (wr_ok) state_d = S_DATA;
      S_DATA:   if (wr_ok && wcnt_q == LAST_W) state_d = S_CHECK;
      S_CHECK:  if (wr_ok) state_d = S_FOOTER;
      S_FOOTER: if (wr_ok) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    fifo_wr_o   = wr_ok;
    busy_o      = (state_q != S_IDLE);
    fifo_data_o = '0;
    case (state_q)
      S_HEADER: fifo_data_o = header_w;
      S_DATA:   fifo_data_o = data_word;
      S_CHECK:  fifo_data_o = csum_q;
      S_FOOTER: fifo_data_o = FOOTER_W;
      default:  fifo_data_o = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      pending_q   <= '0;
      overrun_q   <= '0;
      last_q      <= CW'(C - 1);
      ch_q        <= '0;
      wcnt_q      <= '0;
      csum_q      <= '0;
      frame_cnt_q <= '0;
    end else begin
      pending_q <= pending_d;
      overrun_q <= overrun_d;
      if (state_q == S_IDLE && |pending_q) begin
        ch_q   <= arb_ch;
        last_q <= arb_ch;
      end
      if (state_q == S_LOAD) begin
        wcnt_q <= '0;
        csum_q <= '0;
      end
      if (state_q == S_DATA && wr_ok) begin
        wcnt_q <= wcnt_q + 1'b1;
        csum_q <= csum_q ^ data_word;
      end
      if (state_q == S_FOOTER && wr_ok) frame_cnt_q <= frame_cnt_q + 16'd1;
    end
  end

  // Snapshot is wide and fully rewritten on every LOAD, so it carries no reset.
  always_ff @(posedge clk_i) begin
    if (state_q == S_LOAD) snap_q <= data_i[int'(ch_q)*K*N +: K*N];
  end

  assign frame_cnt_o = frame_cnt_q;
  assign pending_o   = pending_q;
  assign overrun_o   = overrun_q;

endmodule
